// File: rtl/cpu_pkg.sv
// Shared CPU definitions: pipeline bubble, loader state encoding and opcodes
// used by the instruction memory loader and the decoder.
package cpu_pkg;

  localparam logic [15:0] NOP_INSTR = 16'b0110_1111_0000_1111;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    WRITE   = 3'd2,
    CHECK   = 3'd3,
    DONE    = 3'd4
  } ld_state_e;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_LD   = 4'h8;
  localparam logic [3:0] OP_ST   = 4'h9;
  localparam logic [3:0] OP_BR   = 4'hC;
  localparam logic [3:0] OP_JMP  = 4'hD;
  localparam logic [3:0] OP_NOP  = 4'h6;

  // Modulo-256 accumulation used by the load checksum.
  function automatic logic [7:0] add8(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

endpackage

// File: rtl/imem_ram.sv
// Single-clock 1R1W instruction RAM with a registered read port; contents
// are never reset so it maps onto block RAM.
module imem_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/imem_uart_loader.sv
// Instruction memory with a UART byte-stream program loader; fetch is blocked while loading.
// Optional trailing checksum byte enabled by defining IMEM_LOAD_CHECKSUM_EN.
module imem_uart_loader
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              fetch_en,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [DATA_W-1:0] fetch_instr,
  output logic              fetch_valid,
  input  logic              ld_start,
  input  logic [ADDR_W-1:0] ld_base,
  input  logic [ADDR_W-1:0] ld_count,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              ld_busy,
  output logic              ld_done,
  output logic              ld_err
);

  localparam int BPW = DATA_W / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

  ld_state_e         state_reg, state_next;
  logic [ADDR_W-1:0] ptr_reg, ptr_next;
  logic [ADDR_W-1:0] remaining_reg, remaining_next;
  logic [BCW-1:0]    byte_cnt_reg, byte_cnt_next;
  logic [DATA_W-1:0] word_reg, word_next;
  logic              err_reg, err_next;
  logic              zero_done_reg, zero_done_next;
  logic              fetch_valid_reg;
  logic [DATA_W-1:0] shifted_word;
  logic [DATA_W-1:0] ram_rdata;
  logic              ram_we;
  logic              ram_re;
`ifdef IMEM_LOAD_CHECKSUM_EN
  logic [7:0]        sum_reg, sum_next;
`endif

  // Big-endian packing: every byte lane moves up one slot, the new byte enters the bottom.
  genvar gi;
  generate
    for (gi = 0; gi < BPW; gi++) begin : g_pack
      if (gi == 0) begin : g_low
        assign shifted_word[7:0] = rx_data;
      end else begin : g_up
        assign shifted_word[gi*8 +: 8] = word_reg[(gi-1)*8 +: 8];
      end
    end
  endgenerate

  assign ld_busy     = (state_reg != IDLE);
  assign ld_done     = (state_reg == DONE) | zero_done_reg;
  assign ld_err      = err_reg;
`ifdef IMEM_LOAD_CHECKSUM_EN
  assign rx_ready    = (state_reg == COLLECT) | (state_reg == CHECK);
`else
  assign rx_ready    = (state_reg == COLLECT);
`endif
  assign ram_we      = (state_reg == WRITE);
  assign ram_re      = fetch_en & ~ld_busy;
  // Masking with ld_busy also hides a read that was in flight when a load began.
  assign fetch_valid = fetch_valid_reg & ~ld_busy;
  assign fetch_instr = fetch_valid ? ram_rdata : DATA_W'(NOP_INSTR);

  imem_ram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk  (clk),
    .we   (ram_we),
    .waddr(ptr_reg),
    .wdata(word_reg),
    .re   (ram_re),
    .raddr(fetch_addr),
    .rdata(ram_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_reg       <= IDLE;
      ptr_reg         <= '0;
      remaining_reg   <= '0;
      byte_cnt_reg    <= '0;
      word_reg        <= '0;
      err_reg         <= 1'b0;
      zero_done_reg   <= 1'b0;
      fetch_valid_reg <= 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_reg         <= '0;
`endif
    end else begin
      state_reg       <= state_next;
      ptr_reg         <= ptr_next;
      remaining_reg   <= remaining_next;
      byte_cnt_reg    <= byte_cnt_next;
      word_reg        <= word_next;
      err_reg         <= err_next;
      zero_done_reg   <= zero_done_next;
      fetch_valid_reg <= ram_re;
`ifdef IMEM_LOAD_CHECKSUM_EN
      sum_reg         <= sum_next;
`endif
    end
  end

  always_comb begin
    state_next     = state_reg;
    ptr_next       = ptr_reg;
    remaining_next = remaining_reg;
    byte_cnt_next  = byte_cnt_reg;
    word_next      = word_reg;
    err_next       = err_reg;
    zero_done_next = 1'b0;
`ifdef IMEM_LOAD_CHECKSUM_EN
    sum_next       = sum_reg;
`endif
    case (state_reg)
      IDLE: begin
        if (ld_start) begin
          err_next = 1'b0;
          if (ld_count != '0) begin
            ptr_next       = ld_base;
            remaining_next = ld_count;
            byte_cnt_next  = '0;
            state_next     = COLLECT;
`ifdef IMEM_LOAD_CHECKSUM_EN
            sum_next       = '0;
`endif
          end else begin
            zero_done_next = 1'b1;
          end
        end
      end
      COLLECT: begin
        if (rx_valid) begin
          word_next = shifted_word;
`ifdef IMEM_LOAD_CHECKSUM_EN
          sum_next  = add8(sum_reg, rx_data);
`endif
          if (byte_cnt_reg == LAST_BYTE) begin
            byte_cnt_next = '0;
            state_next    = WRITE;
          end else begin
            byte_cnt_next = byte_cnt_reg + BCW'(1);
          end
        end
      end
      WRITE: begin
        ptr_next       = ptr_reg + ADDR_W'(1);
        remaining_next = remaining_reg - ADDR_W'(1);
        if (remaining_reg == ADDR_W'(1)) begin
`ifdef IMEM_LOAD_CHECKSUM_EN
          state_next = CHECK;
`else
          state_next = DONE;
`endif
        end else if (ptr_reg == '1) begin
          // Top of memory reached with words still owed: abort rather than wrap.
          err_next   = 1'b1;
          state_next = IDLE;
        end else begin
          state_next = COLLECT;
        end
      end
`ifdef IMEM_LOAD_CHECKSUM_EN
      CHECK: begin
        if (rx_valid) begin
          if (rx_data == sum_reg) begin
            state_next = DONE;
          end else begin
            err_next   = 1'b1;
            state_next = IDLE;
          end
        end
      end
`endif
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule
